// File: rtl/sram_loader_pkg.sv
// Shared types and width helpers for the SRAM byte loader.
// No logic, no latency.
// No flow control.
package sram_loader_pkg;

    // Load sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Number of byte lanes in one SRAM word
    function automatic int bytes_of(input int data_width);
        return data_width / 8;
    endfunction

    // Width of the byte-lane index
    function automatic int bidx_width(input int data_width);
        return (data_width / 8 > 1) ? $clog2(data_width / 8) : 1;
    endfunction

    // Width of the byte-count input: enough to describe a full-memory load
    function automatic int len_width(input int address_width, input int data_width);
        return address_width + bidx_width(data_width) + 1;
    endfunction

endpackage

// File: rtl/byte_lane_packer.sv
// Assembles bytes little-endian into one word with per-lane enables.
// Lane write visible the cycle after load; clear takes effect next cycle.
// No backpressure: the caller only pulses load when a byte actually transfers.
module byte_lane_packer
    import sram_loader_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int BYTES      = bytes_of(DATA_WIDTH),
    localparam int BIDX_W     = bidx_width(DATA_WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_clear,
    input  logic                  i_load,
    input  logic [7:0]            i_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [BYTES-1:0]      o_byte_en,
    output logic                  o_last_lane
);

    logic [DATA_WIDTH-1:0] lanes_q;
    logic [BYTES-1:0]      byte_en_q;
    logic [BIDX_W-1:0]     idx_q;

    // Lane register: clear wins over load so a finished word never leaks into the next
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            lanes_q   <= '0;
            byte_en_q <= '0;
            idx_q     <= '0;
        end else if (i_clear) begin
            lanes_q   <= '0;
            byte_en_q <= '0;
            idx_q     <= '0;
        end else if (i_load) begin
            for (int k = 0; k < BYTES; k++) begin
                if (idx_q == BIDX_W'(k)) begin
                    lanes_q[8*k +: 8] <= i_data;
                    byte_en_q[k]      <= 1'b1;
                end
            end
            idx_q <= idx_q + BIDX_W'(1);
        end
    end

    assign o_data      = lanes_q;
    assign o_byte_en   = byte_en_q;
    assign o_last_lane = (idx_q == BIDX_W'(BYTES - 1));

endmodule

// File: rtl/sram_byte_loader.sv
// Packs a valid/ready byte stream into words and writes them to SRAM at incrementing addresses.
// Write strobe one cycle after a word's last byte; done pulse one cycle after the final write.
// o_ready drops for the single write cycle of each word, giving BYTES bytes per BYTES+1 cycles.
module sram_byte_loader
    import sram_loader_pkg::*;
#(
    parameter  int DATA_WIDTH    = 32,
    parameter  int ADDRESS_WIDTH = 10,
    parameter  int BASE_ADDRESS  = 0,
    localparam int BYTES         = bytes_of(DATA_WIDTH),
    localparam int LEN_W         = len_width(ADDRESS_WIDTH, DATA_WIDTH)
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_start,
    input  logic [LEN_W-1:0]         i_len,
    input  logic [7:0]               i_data,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic [ADDRESS_WIDTH-1:0] o_address,
    output logic [DATA_WIDTH-1:0]    o_write_data,
    output logic [BYTES-1:0]         o_byte_en,
    output logic                     o_write_en,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_wrapped
);

    localparam logic [ADDRESS_WIDTH-1:0] BASE = ADDRESS_WIDTH'(BASE_ADDRESS);

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [LEN_W-1:0]         rem_q;
    logic                     wrapped_q;
    logic                     ready_q;

    logic xfer;
    logic start_accept;
    logic start_nonzero;
    logic pk_load;
    logic pk_clear;
    logic last_lane;

    assign xfer = i_valid && ready_q;

    byte_lane_packer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_clear     (pk_clear),
        .i_load      (pk_load),
        .i_data      (i_data),
        .o_data      (o_write_data),
        .o_byte_en   (o_byte_en),
        .o_last_lane (last_lane)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and packer controls; a word closes on a full lane set or the final byte
    always_comb begin
        state_d       = state_q;
        start_accept  = 1'b0;
        start_nonzero = 1'b0;
        pk_load       = 1'b0;
        pk_clear      = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    start_accept = 1'b1;
                    if (i_len != '0) begin
                        start_nonzero = 1'b1;
                        pk_clear      = 1'b1;
                        state_d       = FILL;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            FILL: begin
                if (xfer) begin
                    pk_load = 1'b1;
                    if (last_lane || rem_q == LEN_W'(1)) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                pk_clear = 1'b1;
                state_d  = (rem_q == '0) ? DONE : FILL;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Address, remaining count, wrap flag and registered ready
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            addr_q    <= BASE;
            rem_q     <= '0;
            wrapped_q <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            ready_q <= (state_d == FILL);
            if (start_accept) begin
                wrapped_q <= 1'b0;
            end
            if (start_nonzero) begin
                addr_q <= BASE;
                rem_q  <= i_len;
            end
            if (pk_load) begin
                rem_q <= rem_q - LEN_W'(1);
            end
            if (state_q == WRITE) begin
                addr_q <= addr_q + ADDRESS_WIDTH'(1);
                if (addr_q == '1) begin
                    wrapped_q <= 1'b1;
                end
            end
        end
    end

    assign o_ready    = ready_q;
    assign o_address  = addr_q;
    assign o_write_en = (state_q == WRITE);
    assign o_busy     = (state_q != IDLE);
    assign o_done     = (state_q == DONE);
    assign o_wrapped  = wrapped_q;

endmodule

// File: tb/tb_sram_byte_loader.sv
// Randomized bench for sram_byte_loader against a word-list reference model.
// Inputs driven on negedge, outputs sampled on negedge.
// Stream bubbles and spurious starts exercise flow control.
module tb_sram_byte_loader;

    localparam int DW   = 32;
    localparam int AW   = 4;
    localparam int BASE = 14;
    localparam int NB   = DW / 8;
    localparam int LW   = AW + 2 + 1;

    logic          clk  = 1'b0;
    logic          rstn = 1'b1;
    logic          i_start;
    logic [LW-1:0] i_len;
    logic [7:0]    i_data;
    logic          i_valid;
    logic          o_ready;
    logic [AW-1:0] o_address;
    logic [DW-1:0] o_write_data;
    logic [NB-1:0] o_byte_en;
    logic          o_write_en;
    logic          o_busy;
    logic          o_done;
    logic          o_wrapped;

    int total = 0;
    int bad   = 0;

    logic [7:0] bq[$];

    always #5 clk = ~clk;

    sram_byte_loader #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .BASE_ADDRESS  (BASE)
    ) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_start      (i_start),
        .i_len        (i_len),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .o_address    (o_address),
        .o_write_data (o_write_data),
        .o_byte_en    (o_byte_en),
        .o_write_en   (o_write_en),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_wrapped    (o_wrapped)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ready"},   64'(o_ready),      64'(0));
        check_val({tag, "_wen"},     64'(o_write_en),   64'(0));
        check_val({tag, "_busy"},    64'(o_busy),       64'(0));
        check_val({tag, "_done"},    64'(o_done),       64'(0));
        check_val({tag, "_wrapped"}, 64'(o_wrapped),    64'(0));
        check_val({tag, "_addr"},    64'(o_address),    64'(BASE));
        check_val({tag, "_data"},    64'(o_write_data), 64'(0));
        check_val({tag, "_be"},      64'(o_byte_en),    64'(0));
    endtask

    task automatic fill_random(input int n);
        bq.delete();
        repeat (n) bq.push_back(8'($urandom));
    endtask

    // mode 0: valid every cycle, 1: fixed 1,0,0,1,1,0,1 pattern, 2: random bubbles
    function automatic bit valid_choice(input int mode, input int it);
        bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        if (mode == 0) return 1'b1;
        if (mode == 1) return pat[(it - 1) % 7];
        return 1'($urandom_range(0, 1));
    endfunction

    // Runs one load of bq[0..len-1]; must be called right after a negedge with the DUT idle
    task automatic run_load(input int len, input int mode, input bit busy_starts);
        logic [DW-1:0] ed[$];
        logic [AW-1:0] ea[$];
        logic [NB-1:0] eb[$];
        logic [DW-1:0] d;
        logic [NB-1:0] b;
        int  nw, bp, wi, ph, budget;
        bit  exp_wr, seen_done, v;

        // Reference: list of words the memory must receive, and whether the address passes all-ones
        nw     = (len + NB - 1) / NB;
        exp_wr = 1'b0;
        for (int w = 0; w < nw; w++) begin
            int a = (BASE + w) % (1 << AW);
            if (a == (1 << AW) - 1) exp_wr = 1'b1;
            d = '0;
            b = '0;
            for (int k = 0; k < NB; k++) begin
                if (w * NB + k < len) begin
                    d    = d | (DW'(bq[w * NB + k]) << (8 * k));
                    b[k] = 1'b1;
                end
            end
            ea.push_back(AW'(a));
            ed.push_back(d);
            eb.push_back(b);
        end

        i_start = 1'b1;
        i_len   = LW'(len);
        i_valid = 1'b0;
        bp = 0;
        wi = 0;
        ph = (len > 0) ? 1 : 3;   // 1 = accepting bytes, 2 = word write, 3 = completion
        seen_done = 1'b0;
        budget = 20 * len + 40;

        for (int it = 1; it <= budget && !seen_done; it++) begin
            @(negedge clk);
            i_start = busy_starts ? (($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0) : 1'b0;
            i_len   = LW'($urandom);
            if (it == 1) check_val("wrapped_clr", 64'(o_wrapped), 64'(0));
            check_val("busy",  64'(o_busy),     64'(1));
            check_val("ready", 64'(o_ready),    64'(ph == 1));
            check_val("wen",   64'(o_write_en), 64'(ph == 2));
            check_val("done",  64'(o_done),     64'(ph == 3));
            case (ph)
                1: begin
                    v       = (bp < len) && valid_choice(mode, it);
                    i_valid = v;
                    i_data  = v ? bq[bp] : 8'($urandom);
                    if (v) begin
                        bp++;
                        if ((bp % NB) == 0 || bp == len) ph = 2;
                    end
                end
                2: begin
                    if (wi < nw) begin
                        check_val("w_addr", 64'(o_address),    64'(ea[wi]));
                        check_val("w_data", 64'(o_write_data), 64'(ed[wi]));
                        check_val("w_be",   64'(o_byte_en),    64'(eb[wi]));
                    end else begin
                        check_val("extra_write", 64'(wi), 64'(nw));
                    end
                    wi++;
                    i_valid = 1'($urandom_range(0, 1));
                    i_data  = 8'($urandom);
                    ph = (bp == len) ? 3 : 1;
                end
                default: begin
                    seen_done = 1'b1;
                    i_start   = 1'b0;
                    i_valid   = 1'b0;
                end
            endcase
        end
        if (!seen_done) check_val("timeout", 64'(0), 64'(1));
        check_val("n_writes", 64'(wi), 64'(nw));

        @(negedge clk);
        i_start = 1'b0;
        i_valid = 1'b0;
        check_val("idle_busy",    64'(o_busy),     64'(0));
        check_val("idle_done",    64'(o_done),     64'(0));
        check_val("idle_wen",     64'(o_write_en), 64'(0));
        check_val("idle_ready",   64'(o_ready),    64'(0));
        check_val("idle_wrapped", 64'(o_wrapped),  64'(exp_wr));
        @(negedge clk);
        check_val("hold_wrapped", 64'(o_wrapped),  64'(exp_wr));
        check_val("hold_wen",     64'(o_write_en), 64'(0));
    endtask

    initial begin
        i_start = 1'b0;
        i_len   = '0;
        i_data  = '0;
        i_valid = 1'b0;

        #1 rstn = 1'b0;
        #1 check_reset_outputs("rst");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_rst");

        // Two full words, back-to-back bytes
        bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_load(8, 0, 1'b0);

        // Partial tail word
        bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        run_load(5, 0, 1'b0);

        // Zero length
        bq.delete();
        run_load(0, 0, 1'b0);

        // Bubbled stream with spurious starts while busy
        fill_random(4);
        run_load(4, 1, 1'b1);

        // Three words from base 14 cross the top of memory
        fill_random(12);
        run_load(12, 0, 1'b0);

        // Abort after two bytes of a four-byte load
        fill_random(4);
        i_start = 1'b1;
        i_len   = LW'(4);
        @(negedge clk);
        i_start = 1'b0;
        i_valid = 1'b1;
        i_data  = bq[0];
        @(negedge clk);
        i_data  = bq[1];
        @(negedge clk);
        i_valid = 1'b0;
        #3 rstn = 1'b0;
        #1 check_reset_outputs("abort");
        repeat (3) begin
            @(negedge clk);
            check_val("abort_wen",  64'(o_write_en), 64'(0));
            check_val("abort_done", 64'(o_done),     64'(0));
        end
        rstn = 1'b1;
        @(negedge clk);

        // Fresh short load after the abort must carry no stale lanes
        fill_random(3);
        run_load(3, 0, 1'b0);

        // Random loads
        for (int n = 0; n < 30; n++) begin
            int len = $urandom_range(0, 20);
            fill_random(len);
            run_load(len, $urandom_range(0, 2), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
